bitonic_sort_pipe: RTL and testbench
====================================

Name: bitonic_sort_pipe

Overview:
- Parametrised, fully pipelined bitonic sorting network for N = 2**LOG2_N unsigned keys of DATA_W bits.
- Successor to the fixed 16 x 8-bit combinational hypercube sorter.
- Adds a per-vector ascending/descending mode, valid/ready flow control, and one register per compare-exchange column.
- Accepts one vector per cycle; sits between a vector producer and consumer in the sort datapath.

Parameters:
- DATA_W, 8: key width in bits (>=1).
- LOG2_N, 4: log2 of element count; N = 2**LOG2_N, supported 1..6.
- IDX_W, LOG2_N (derived, localparam): width of the original-position tag (used only with the optional feature).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  sorter can accept a vector this cycle.
- in_desc  in  1  0 = sort ascending, 1 = descending; sampled with the vector.
- in_data  in  N*DATA_W  element i at bits [i*DATA_W +: DATA_W].
- out_valid  out  1  sorted vector valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_desc  out  1  mode the vector was sorted with.
- out_data  out  N*DATA_W  sorted elements; element 0 = first in sort order.
- out_idx  out  N*IDX_W  original input position of each output element (only when SORT_INDEX_EN is defined).

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Network:
  - Standard bitonic network with S = LOG2_N*(LOG2_N+1)/2 compare-exchange columns; each column is followed by a register stage.
  - Latency is S cycles from an input handshake to out_valid with no stall (N=16: 10 cycles; N=2: 1 cycle).
- Compare-exchange:
  - Unsigned compare, swap only when strictly out of order, so equal keys never swap.
  - Per-pair direction follows the bitonic pattern; the final direction is XORed with the vector's desc bit, which travels down the pipeline alongside the data.
- Pipeline control:
  - Per-stage valid bit v[0..S-1].
  - adv = out_ready | ~v[S-1]. When adv = 1, all stages shift by one; when adv = 0, all stages hold.
  - in_ready = adv, combinational from out_ready and v[S-1]. No combinational path from in_valid to in_ready.
  - Stage-0 valid loads (in_valid & in_ready). Data/desc registers load on adv regardless of valid; payload of an invalid stage is don't-care.
  - out_valid = v[S-1]. out_data and out_desc are the stage S-1 registers and are held stable while out_valid & ~out_ready.
- Bubbles: not collapsed; a bubble occupies a stage, and throughput is 1 vector/cycle when out_ready stays high.
- Reset: all v[] cleared to 0 in the same cycle, so out_valid = 0 on the first cycle after rst.
  - in_ready = 1 while rst is high (v[S-1] = 0).
  - Data registers are not reset; out_data/out_desc are X/don't-care until the first valid output.
  - rst mid-operation discards every in-flight vector; no partial output is ever produced.
- Simultaneous events:
  - An input handshake and an output handshake in the same cycle are legal and are the steady state.
  - in_valid during rst is ignored.
- Boundary: N = 2 gives a single compare-exchange (S = 1); LOG2_N = 1 must elaborate.

Optional Feature:
- Macro SORT_INDEX_EN.
- Defined:
  - Each element carries an IDX_W tag initialised to its input position i; tags swap together with keys.
  - out_idx is present and aligned with out_data.
  - Tags are not reset and are don't-care when out_valid = 0.
- Undefined: no tag registers and no out_idx port; area is keys plus the desc bit only.

Test Plan:
1. N=16, DATA_W=8, out_ready=1. Input elements 0..15 = 03,05,08,09,0A,0C,0E,14,5F,5A,3C,28,23,17,12,00, desc=0. Expected: out_valid exactly 10 cycles later, out_data elements 0..15 = 00,03,05,08,09,0A,0C,0E,12,14,17,23,28,3C,5A,5F. With SORT_INDEX_EN, out_idx = 15,0,1,2,3,4,5,6,14,7,13,12,11,10,9,8.
2. Same vector with desc=1. Expected: reversed order 5F..00 and out_desc=1.
3. Back-to-back streaming: 20 random vectors on consecutive cycles, alternating desc, out_ready=1. Expected: 20 outputs on consecutive cycles, in order, each matching a software reference sort.
4. Backpressure: out_ready=0 for 5 cycles while outputs are valid. Expected: in_ready=0, out_data stable and no vector lost or duplicated; stream resumes in order after out_ready returns to 1.
5. All-equal input (every element = 7A) and all-zero input. Expected: output equal to input. With SORT_INDEX_EN, out_idx = 0..15 unchanged (no swaps on ties).
6. rst asserted for 1 cycle with 4 vectors in flight. Expected: out_valid=0 on the next cycle and no stale vector is ever emitted. A new vector accepted afterwards appears after exactly 10 cycles. Repeat case 1 with LOG2_N=1 and DATA_W=16: input {1234, 0001} gives out {0001, 1234} after 1 cycle.

Source files
------------

// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorter: N = 2**LOG2_N unsigned keys, one register per column.
// Define SORT_INDEX_EN to carry original-position tags (out_idx) with the keys.
module bitonic_sort_pipe #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_desc,
  input  logic [(2**LOG2_N)*DATA_W-1:0]    in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_desc,
  output logic [(2**LOG2_N)*DATA_W-1:0]    out_data
`ifdef SORT_INDEX_EN
  ,
  output logic [(2**LOG2_N)*LOG2_N-1:0]    out_idx
`endif
);

  localparam int N = 2 ** LOG2_N;
  localparam int S = LOG2_N * (LOG2_N + 1) / 2;
`ifdef SORT_INDEX_EN
  localparam int IDX_W = LOG2_N;
`endif

  logic [S-1:0]      v_q;
  logic [S-1:0]      v_d;
  logic              adv;
  logic [DATA_W-1:0] in_key [N];
  logic [DATA_W-1:0] key_d  [S][N];
  logic [DATA_W-1:0] key_q  [S][N];
  logic              desc_d [S];
  logic              desc_q [S];
`ifdef SORT_INDEX_EN
  logic [IDX_W-1:0]  in_tag [N];
  logic [IDX_W-1:0]  idx_d  [S][N];
  logic [IDX_W-1:0]  idx_q  [S][N];
`endif

  assign adv       = out_ready | ~v_q[S-1];
  assign in_ready  = adv;
  assign out_valid = v_q[S-1];
  assign out_desc  = desc_q[S-1];

  for (genvar i = 0; i < N; i++) begin : g_io
    assign in_key[i] = in_data[i*DATA_W +: DATA_W];
    assign out_data[i*DATA_W +: DATA_W] = key_q[S-1][i];
`ifdef SORT_INDEX_EN
    assign in_tag[i] = IDX_W'(i);
    assign out_idx[i*IDX_W +: IDX_W] = idx_q[S-1][i];
`endif
  end

  for (genvar k = 1; k <= LOG2_N; k++) begin : g_stage
    for (genvar jj = 0; jj < k; jj++) begin : g_col
      localparam int C = k * (k - 1) / 2 + jj;
      localparam int J = k - 1 - jj;

      logic [DATA_W-1:0] cin [N];
`ifdef SORT_INDEX_EN
      logic [IDX_W-1:0]  tin [N];
`endif

      if (C == 0) begin : g_d0
        assign desc_d[C] = in_desc;
      end else begin : g_dq
        assign desc_d[C] = desc_q[C-1];
      end

      for (genvar i = 0; i < N; i++) begin : g_in
        if (C == 0) begin : g_s0
          assign cin[i] = in_key[i];
`ifdef SORT_INDEX_EN
          assign tin[i] = in_tag[i];
`endif
        end else begin : g_sq
          assign cin[i] = key_q[C-1][i];
`ifdef SORT_INDEX_EN
          assign tin[i] = idx_q[C-1][i];
`endif
        end
      end

      for (genvar i = 0; i < N; i++) begin : g_pair
        if (((i >> J) & 1) == 0) begin : g_cx
          localparam int P  = i + (1 << J);
          localparam bit UP = ((i >> k) & 1) == 0;

          logic dn;
          logic swap;

          assign dn   = desc_d[C] ^ (UP ? 1'b0 : 1'b1);
          assign swap = dn ? (cin[i] < cin[P])
                           : (cin[i] > cin[P]);

          assign key_d[C][i] = swap ? cin[P] : cin[i];
          assign key_d[C][P] = swap ? cin[i] : cin[P];
`ifdef SORT_INDEX_EN
          assign idx_d[C][i] = swap ? tin[P] : tin[i];
          assign idx_d[C][P] = swap ? tin[i] : tin[P];
`endif
        end
      end
    end
  end

  // next valid vector: shift toward the output, new entry at stage 0
  always_comb begin
    v_d    = v_q << 1;
    v_d[0] = in_valid;
  end

  // valid chain: cleared on reset, moves only when the pipe advances
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (adv) begin
      v_q <= v_d;
    end
  end

  // payload registers: unreset, load on every advance
  always_ff @(posedge clk) begin
    if (adv) begin
      key_q  <= key_d;
      desc_q <= desc_d;
`ifdef SORT_INDEX_EN
      idx_q  <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Directed bench for bitonic_sort_pipe: N=16 x 8-bit plus an N=2 x 16-bit instance.
// In-order scoreboard with hand-computed or reference-sorted expectations.
module tb_bitonic_sort_pipe;

  localparam int S = 10;

  typedef struct {
    logic [127:0] data;
    logic         desc;
    logic [63:0]  idx;
    logic [127:0] orig;
    bit           lat;
    bit           idx_exact;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_desc;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_desc;
  logic [127:0] out_data;
`ifdef SORT_INDEX_EN
  logic [63:0]  out_idx;
`endif

  logic         s_in_valid;
  logic         s_in_ready;
  logic         s_in_desc;
  logic [31:0]  s_in_data;
  logic         s_out_valid;
  logic         s_out_ready;
  logic         s_out_desc;
  logic [31:0]  s_out_data;
`ifdef SORT_INDEX_EN
  logic [1:0]   s_out_idx;
`endif

  always #5 clk = ~clk;

  bitonic_sort_pipe #(.DATA_W(8), .LOG2_N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_desc  (out_desc),
    .out_data  (out_data)
`ifdef SORT_INDEX_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  bitonic_sort_pipe #(.DATA_W(16), .LOG2_N(1)) dut_n2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_desc   (s_in_desc),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_desc  (s_out_desc),
    .out_data  (s_out_data)
`ifdef SORT_INDEX_EN
    ,
    .out_idx   (s_out_idx)
`endif
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   cyc = 0;
  exp_t exp_q [$];
  int   acc_q [$];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_sort(input logic [127:0] d,
                                            input logic ds);
    logic [7:0]   a [16];
    logic [7:0]   t;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = d[i*8 +: 8];
    for (int i = 1; i < 16; i++) begin
      for (int j = i; j > 0; j--) begin
        if (ds ? (a[j] > a[j-1]) : (a[j] < a[j-1])) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  function automatic exp_t mk(input logic [127:0] d, input logic ds,
                              input logic [127:0] e, input logic [63:0] ix,
                              input bit lat, input bit exact);
    exp_t x;
    x.data = e; x.desc = ds; x.idx = ix;
    x.orig = d; x.lat = lat; x.idx_exact = exact;
    return x;
  endfunction

  function automatic exp_t mk_rand(input logic [127:0] d, input logic ds,
                                   input bit lat);
    return mk(d, ds, ref_sort(d, ds), '0, lat, 1'b0);
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) cyc++;

  exp_t         m_e;
  int           m_a;
`ifdef SORT_INDEX_EN
  logic [127:0] m_g;
  int           m_k;
`endif

  // scoreboard: note accept cycles, compare every output handshake in order
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          m_a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
          n_out++;
          chk("out_data", out_data, m_e.data);
          chk("out_desc", out_desc, m_e.desc);
          if (m_e.lat) chk("latency", cyc - m_a, S);
`ifdef SORT_INDEX_EN
          if (m_e.idx_exact) begin
            chk("out_idx", out_idx, m_e.idx);
          end else begin
            for (int j = 0; j < 16; j++) begin
              m_k = int'(out_idx[j*4 +: 4]);
              m_g[j*8 +: 8] = m_e.orig[m_k*8 +: 8];
            end
            chk("idx_keys", m_g, out_data);
          end
`endif
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic ds, input exp_t e);
    in_valid = 1'b1;
    in_data  = d;
    in_desc  = ds;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("in_ready_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  localparam logic [127:0] T1     = 128'h00121723283C5A5F140E0C0A09080503;
  localparam logic [127:0] T1_ASC = 128'h5F5A3C28231714120E0C0A0908050300;
  localparam logic [127:0] T1_DSC = 128'h00030508090A0C0E12141723283C5A5F;
  localparam logic [63:0]  I_ASC  = 64'h89ABCD7E6543210F;
  localparam logic [63:0]  I_DSC  = 64'hF0123456E7DCBA98;
  localparam logic [63:0]  I_ID   = 64'hFEDCBA9876543210;
  localparam logic [127:0] ALL7A  = {16{8'h7A}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    logic [127:0] held;
    int           base;
    rst = 1'b1; in_valid = 1'b0; in_desc = 1'b0; in_data = '0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_desc = 1'b0; s_in_data = '0;
    s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_n2_out_valid", s_out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(T1, 1'b0, mk(T1, 1'b0, T1_ASC, I_ASC, 1'b1, 1'b1));
    drain();
    send(T1, 1'b1, mk(T1, 1'b1, T1_DSC, I_DSC, 1'b1, 1'b1));
    drain();

    send(ALL7A, 1'b0, mk(ALL7A, 1'b0, ALL7A, I_ID, 1'b1, 1'b1));
    send('0, 1'b0, mk('0, 1'b0, '0, I_ID, 1'b1, 1'b1));
    send(ALL7A, 1'b1, mk(ALL7A, 1'b1, ALL7A, I_ID, 1'b1, 1'b1));
    drain();

    base = n_out;
    for (int v = 0; v < 20; v++) begin
      d = rnd();
      send(d, v[0], mk_rand(d, v[0], 1'b1));
    end
    drain();
    chk("stream_count", n_out - base, 20);

    base = n_out;
    fork
      begin
        logic [127:0] dd;
        for (int v = 0; v < 12; v++) begin
          dd = rnd();
          send(dd, v[0], mk_rand(dd, v[0], 1'b0));
        end
      end
      begin
        repeat (11) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        chk("stall_valid", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_hold", out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", n_out - base, 12);

    for (int v = 0; v < 4; v++) begin
      d = rnd();
      send(d, 1'b0, mk_rand(d, 1'b0, 1'b0));
    end
    rst = 1'b1;
    in_valid = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(T1, 1'b0, mk(T1, 1'b0, T1_ASC, I_ASC, 1'b1, 1'b1));
    drain();

    s_in_valid = 1'b1;
    s_in_desc  = 1'b0;
    s_in_data  = {16'h0001, 16'h1234};
    @(negedge clk);
    chk("n2_in_ready", s_in_ready, 1);
    chk("n2_pre_valid", s_out_valid, 0);
    @(posedge clk); #1;
    s_in_desc = 1'b1;
    s_in_data = {16'h1234, 16'h0001};
    @(negedge clk);
    chk("n2_asc_valid", s_out_valid, 1);
    chk("n2_asc_data", s_out_data, {16'h1234, 16'h0001});
    chk("n2_asc_desc", s_out_desc, 0);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("n2_dsc_valid", s_out_valid, 1);
    chk("n2_dsc_data", s_out_data, {16'h0001, 16'h1234});
    chk("n2_dsc_desc", s_out_desc, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("n2_idle_valid", s_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
